ysyx_22051013_axi_sram_slave: RTL and testbench
===============================================

# ysyx_22051013_axi_sram_slave

AXI4 responder backed by an on-chip word-addressed memory array; the counterpart to the core-side AXI master arbitrator. Sits on the far side of the core's AXI port in simulation and SoC-less builds and serves instruction fetches, loads and stores. Read and write channels run independent state machines; single-beat and INCR/FIXED bursts are supported, with a configurable read latency.

## Interface
- ADDR_W, 32, address width
- DATA_W, 64, data width; byte lanes = DATA_W/8 = 8
- ID_W, 4, transaction ID width
- DEPTH, 4096, memory depth in DATA_W words; valid byte range is 0 to DEPTH*8-1
- READ_LAT, 1, idle cycles between AR handshake+1 and first rvalid (0 allowed)
- clk  in  1  clock; one clock, all logic on posedge
- rst  in  1  reset; synchronous, active-high
- axi_aw_id/addr/len/size/burst  in  ID_W/ADDR_W/8/3/2  write address
- axi_aw_valid in 1; axi_aw_ready out 1
- axi_w_data/strb/last  in  DATA_W/8/1  write data; axi_w_valid in 1; axi_w_ready out 1
- axi_b_id/resp  out  ID_W/2; axi_b_valid out 1; axi_b_ready in 1
- axi_ar_id/addr/len/size/burst  in  ID_W/ADDR_W/8/3/2  read address
- axi_ar_valid in 1; axi_ar_ready out 1
- axi_r_id/data/resp/last  out  ID_W/DATA_W/2/1; axi_r_valid out 1; axi_r_ready in 1

## Operation
- Beats per burst = len+1. Beat address: INCR adds 1<<size per beat; FIXED holds. Word index = addr >> 3.
- Error (resp 2'b10 SLVERR, whole burst): burst==WRAP(2'b10) or reserved(2'b11), size>3, or any beat word index >= DEPTH. Errors are evaluated per beat for range; once any beat errs, final bresp is SLVERR. Erroneous beats never write; erroneous read beats return data 0 with rresp SLVERR. Otherwise resp 2'b00.
- Write FSM: W_IDLE (aw_ready=1) --aw handshake--> W_DATA (latch id, addr, len, size, burst; w_ready=1). Each w handshake writes mem[idx] byte lanes where strb=1, advances address/beat counter. Beat with w_last=1, or beat counter reaching len, -> W_RESP (b_valid=1, b_id=latched id). w_last mismatch with counter: burst ends on whichever comes first; resp SLVERR. W_RESP --b handshake--> W_IDLE.
- W data before AW: not accepted (w_ready=0 outside W_DATA).
- Read FSM: R_IDLE (ar_ready=1) --ar handshake--> R_WAIT (latch; counter loads READ_LAT) --counter==0--> R_DATA; READ_LAT=0 goes straight to R_DATA. R_DATA: r_valid=1, r_data=mem[idx] combinational, r_id latched, r_last=1 on beat len. On r handshake advance address; after last beat -> R_IDLE. Outputs held stable while r_valid=1 and r_ready=0.
- Read/write collision: write committed at edge t is visible to r_data from cycle t+1; r_data may change while stalled only if the same word is written (accepted hazard, documented).
- Memory contents are not reset.

## Timing
- Reset (and 1 cycle after deassertion): aw_ready=1, ar_ready=1, w_ready=0, b_valid=0, r_valid=0, r_last=0, b_resp=0, r_resp=0, b_id=0, r_id=0, r_data=0 (r_data forced 0 outside R_DATA).
- AW handshake cycle t -> w_ready=1 from t+1. Final W beat cycle u -> b_valid at u+1. b handshake cycle v -> aw_ready at v+1.
- AR handshake cycle t -> r_valid at t+1+READ_LAT. With r_ready held 1, beats on consecutive cycles. Last r handshake cycle v -> ar_ready at v+1.
- Max throughput: single-beat write every 3 cycles, single-beat read every 2+READ_LAT cycles; read and write proceed concurrently.
- rst during any burst: both FSMs to IDLE next edge; beats already written stay written; no b/r for aborted burst.

## Test plan
- Reset: hold rst 3 cycles -> aw_ready=1, ar_ready=1, all valid=0; release, no spurious handshakes.
- Single write: aw addr 0x10, len 0, size 3; w data 0x1122334455667788, strb 0x0F, last 1 -> b_valid 1 cycle after W, bresp 0; read 0x10 len 0 -> r_data low 4 bytes 0x55667788, upper bytes previous content, r_last=1, r_valid at AR+2 (READ_LAT=1).
- INCR read burst: preload words 0..3 with 0xA0..0xA3, ar addr 0, len 3, size 3, r_ready toggling 1/0 -> 4 beats 0xA0..0xA3 in order, data stable during stalls, r_last only on 4th, r_id echoes ar_id.
- Errors: ar addr DEPTH*8 -> r_resp 2'b10, data 0; aw burst WRAP len 1 -> two W beats consumed, memory unchanged, bresp 2'b10.
- Concurrency: write 0x20 and read 0x28 issued same cycle -> both complete, correct IDs, independent timing; write then read same word -> new value.
- Reset mid-burst: rst after beat 2 of 4-beat write -> FSM idle, no b_valid, words 0,1 written, words 2,3 unchanged.

Source files
------------

// File: rtl/ysyx_22051013_axi_sram_slave.sv
// AXI4 responder over a word-addressed on-chip memory.
// Read and write channels run independent FSMs; supports single beats and INCR/FIXED bursts.
module ysyx_22051013_axi_sram_slave #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ID_W     = 4,
    parameter int unsigned DEPTH    = 4096,
    parameter int unsigned READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ID_W-1:0]   axi_aw_id,
    input  logic [ADDR_W-1:0] axi_aw_addr,
    input  logic [7:0]        axi_aw_len,
    input  logic [2:0]        axi_aw_size,
    input  logic [1:0]        axi_aw_burst,
    input  logic              axi_aw_valid,
    output logic              axi_aw_ready,

    input  logic [DATA_W-1:0]   axi_w_data,
    input  logic [DATA_W/8-1:0] axi_w_strb,
    input  logic                axi_w_last,
    input  logic                axi_w_valid,
    output logic                axi_w_ready,

    output logic [ID_W-1:0]   axi_b_id,
    output logic [1:0]        axi_b_resp,
    output logic              axi_b_valid,
    input  logic              axi_b_ready,

    input  logic [ID_W-1:0]   axi_ar_id,
    input  logic [ADDR_W-1:0] axi_ar_addr,
    input  logic [7:0]        axi_ar_len,
    input  logic [2:0]        axi_ar_size,
    input  logic [1:0]        axi_ar_burst,
    input  logic              axi_ar_valid,
    output logic              axi_ar_ready,

    output logic [ID_W-1:0]   axi_r_id,
    output logic [DATA_W-1:0] axi_r_data,
    output logic [1:0]        axi_r_resp,
    output logic              axi_r_last,
    output logic              axi_r_valid,
    input  logic              axi_r_ready
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned WORD_W = ADDR_W - OFF_W;
    localparam int unsigned LAT_W  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} r_state_e;

    logic [DATA_W-1:0] mem [DEPTH];

    // WRAP, reserved burst types and beats wider than the bus are rejected for the whole burst
    function automatic logic cfg_ok(input logic [2:0] size, input logic [1:0] burst);
        return ((burst == BURST_FIXED) || (burst == BURST_INCR)) && (size <= 3'(OFF_W));
    endfunction

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:OFF_W] < WORD_W'(DEPTH);
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [2:0]        size,
                                                    input logic [1:0]        burst);
        if (burst == BURST_INCR) return a + (ADDR_W'(1) << size);
        return a;
    endfunction

    // ---------------- write channel ----------------
    w_state_e          w_state, w_state_nxt;
    logic [ADDR_W-1:0] w_addr;
    logic [ID_W-1:0]   w_id;
    logic [7:0]        w_len, w_cnt;
    logic [2:0]        w_size;
    logic [1:0]        w_burst;
    logic              w_err;
    logic              aw_hs, w_hs, b_hs;
    logic              w_beat_err, w_at_len, w_final, w_mismatch;
    logic [IDX_W-1:0]  w_idx;

    assign aw_hs      = axi_aw_valid && axi_aw_ready;
    assign w_hs       = axi_w_valid && axi_w_ready;
    assign b_hs       = axi_b_valid && axi_b_ready;
    assign w_beat_err = !cfg_ok(w_size, w_burst) || !in_range(w_addr);
    assign w_at_len   = (w_cnt == w_len);
    assign w_final    = axi_w_last || w_at_len;
    assign w_mismatch = axi_w_last != w_at_len;
    assign w_idx      = w_addr[OFF_W +: IDX_W];

    always_ff @(posedge clk) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = w_state;
        unique case (w_state)
            W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
            W_DATA:  if (w_hs && w_final) w_state_nxt = W_RESP;
            W_RESP:  if (b_hs) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        axi_aw_ready = 1'b0;
        axi_w_ready  = 1'b0;
        axi_b_valid  = 1'b0;
        unique case (w_state)
            W_IDLE:  axi_aw_ready = 1'b1;
            W_DATA:  axi_w_ready  = 1'b1;
            W_RESP:  axi_b_valid  = 1'b1;
            default: ;
        endcase
    end

    // Burst bookkeeping; the response is frozen on the burst's final beat
    always_ff @(posedge clk) begin
        if (rst) begin
            w_addr     <= '0;
            w_id       <= '0;
            w_len      <= '0;
            w_cnt      <= '0;
            w_size     <= '0;
            w_burst    <= '0;
            w_err      <= 1'b0;
            axi_b_id   <= '0;
            axi_b_resp <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                w_addr  <= axi_aw_addr;
                w_id    <= axi_aw_id;
                w_len   <= axi_aw_len;
                w_size  <= axi_aw_size;
                w_burst <= axi_aw_burst;
                w_cnt   <= '0;
                w_err   <= 1'b0;
            end
            if (w_hs) begin
                w_addr <= next_addr(w_addr, w_size, w_burst);
                w_cnt  <= w_cnt + 8'd1;
                w_err  <= w_err || w_beat_err || w_mismatch;
                if (w_final) begin
                    axi_b_id   <= w_id;
                    axi_b_resp <= (w_err || w_beat_err || w_mismatch) ? RESP_SLVERR : RESP_OKAY;
                end
            end
        end
    end

    // Memory contents survive reset; a beat arriving with reset asserted is dropped
    always_ff @(posedge clk) begin
        if (w_hs && !rst && !w_beat_err) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (axi_w_strb[b]) mem[w_idx][b*8 +: 8] <= axi_w_data[b*8 +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    r_state_e          r_state, r_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len, r_cnt;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic [LAT_W-1:0]  lat_cnt;
    logic              ar_hs, r_hs, r_beat_err;
    logic [IDX_W-1:0]  r_idx;

    assign ar_hs      = axi_ar_valid && axi_ar_ready;
    assign r_hs       = axi_r_valid && axi_r_ready;
    assign r_beat_err = !cfg_ok(r_size, r_burst) || !in_range(r_addr);
    assign r_idx      = r_addr[OFF_W +: IDX_W];

    always_ff @(posedge clk) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_state_nxt;
    end

    always_comb begin
        r_state_nxt = r_state;
        unique case (r_state)
            R_IDLE:  if (ar_hs) r_state_nxt = (READ_LAT == 0) ? R_DATA : R_WAIT;
            R_WAIT:  if (lat_cnt == '0) r_state_nxt = R_DATA;
            R_DATA:  if (r_hs && (r_cnt == r_len)) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // Read data is looked up live, so a write to the stalled word shows through
    always_comb begin
        axi_ar_ready = 1'b0;
        axi_r_valid  = 1'b0;
        axi_r_last   = 1'b0;
        axi_r_resp   = RESP_OKAY;
        axi_r_data   = '0;
        unique case (r_state)
            R_IDLE: axi_ar_ready = 1'b1;
            R_DATA: begin
                axi_r_valid = 1'b1;
                axi_r_last  = (r_cnt == r_len);
                if (r_beat_err) axi_r_resp = RESP_SLVERR;
                else            axi_r_data = mem[r_idx];
            end
            default: ;
        endcase
    end

    // The wait state itself is one latency cycle, so the counter starts at READ_LAT-1
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_size   <= '0;
            r_burst  <= '0;
            lat_cnt  <= '0;
            axi_r_id <= '0;
        end else begin
            if (ar_hs) begin
                r_addr   <= axi_ar_addr;
                r_len    <= axi_ar_len;
                r_size   <= axi_ar_size;
                r_burst  <= axi_ar_burst;
                r_cnt    <= '0;
                axi_r_id <= axi_ar_id;
                lat_cnt  <= LAT_W'((READ_LAT > 0) ? (READ_LAT - 1) : 0);
            end else if ((r_state == R_WAIT) && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
            end
            if (r_hs) begin
                r_addr <= next_addr(r_addr, r_size, r_burst);
                r_cnt  <= r_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22051013_axi_sram_slave.sv
// Scoreboard bench for the AXI SRAM responder: directed scenarios then randomized traffic
// checked against a byte-level memory model.
module tb_ysyx_22051013_axi_sram_slave;

    localparam int unsigned DEPTH    = 4096;
    localparam int unsigned READ_LAT = 1;
    localparam int          TMO      = 500;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  axi_aw_id, axi_ar_id, axi_b_id, axi_r_id;
    logic [31:0] axi_aw_addr, axi_ar_addr;
    logic [7:0]  axi_aw_len, axi_ar_len;
    logic [2:0]  axi_aw_size, axi_ar_size;
    logic [1:0]  axi_aw_burst, axi_ar_burst, axi_b_resp, axi_r_resp;
    logic        axi_aw_valid, axi_aw_ready, axi_ar_valid, axi_ar_ready;
    logic [63:0] axi_w_data, axi_r_data;
    logic [7:0]  axi_w_strb;
    logic        axi_w_last, axi_w_valid, axi_w_ready;
    logic        axi_b_valid, axi_b_ready;
    logic        axi_r_last, axi_r_valid, axi_r_ready;

    always #5 clk = ~clk;

    ysyx_22051013_axi_sram_slave #(
        .ADDR_W(32), .DATA_W(64), .ID_W(4), .DEPTH(DEPTH), .READ_LAT(READ_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .axi_aw_id(axi_aw_id), .axi_aw_addr(axi_aw_addr), .axi_aw_len(axi_aw_len),
        .axi_aw_size(axi_aw_size), .axi_aw_burst(axi_aw_burst),
        .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready),
        .axi_w_data(axi_w_data), .axi_w_strb(axi_w_strb), .axi_w_last(axi_w_last),
        .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready),
        .axi_b_id(axi_b_id), .axi_b_resp(axi_b_resp), .axi_b_valid(axi_b_valid),
        .axi_b_ready(axi_b_ready),
        .axi_ar_id(axi_ar_id), .axi_ar_addr(axi_ar_addr), .axi_ar_len(axi_ar_len),
        .axi_ar_size(axi_ar_size), .axi_ar_burst(axi_ar_burst),
        .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready),
        .axi_r_id(axi_r_id), .axi_r_data(axi_r_data), .axi_r_resp(axi_r_resp),
        .axi_r_last(axi_r_last), .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready)
    );

    typedef struct { logic [3:0] id; logic [63:0] data; logic [63:0] mask; logic [1:0] resp; logic last; } rexp_t;
    typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;

    rexp_t       r_q[$];
    bexp_t       b_q[$];
    int          checks = 0;
    int          failures = 0;
    int          rr_mode = 0;
    int          bb_mode = 0;
    logic [63:0] mw [DEPTH];
    logic [63:0] mm [DEPTH];
    logic [63:0] wd [16];
    logic [7:0]  ws [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int i,
                                              input logic [2:0] sz, input logic [1:0] bu);
        return (bu == 2'b01) ? a + (32'(i) << sz) : a;
    endfunction

    function automatic bit beat_err(input logic [31:0] a, input logic [2:0] sz, input logic [1:0] bu);
        return (bu[1] == 1'b1) || (sz > 3'd3) || ((a >> 3) >= 32'(DEPTH));
    endfunction

    // Waits for a selected condition at negedges; n is the number of negedges taken
    task automatic wait_hi(input int sel, input string name, output int n);
        bit hit;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            case (sel)
                0: hit = axi_aw_ready;
                1: hit = axi_w_ready;
                2: hit = axi_ar_ready;
                default: hit = axi_r_valid;
            endcase
        end while (!hit && n < TMO);
        if (!hit) begin
            checks++; failures++;
            $display("FAIL %s_timeout actual=low required=high", name);
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [2:0] sz, input logic [1:0] bu, input int last_at,
                            input int abort_n, input bit chk_lat);
        int nb, n;
        bit any_err;
        logic [31:0] a;
        nb = ((last_at < len) ? last_at : len) + 1;
        if (abort_n >= 0 && abort_n < nb) nb = abort_n;
        any_err = (last_at != len);
        axi_aw_id = id; axi_aw_addr = addr; axi_aw_len = 8'(len);
        axi_aw_size = sz; axi_aw_burst = bu; axi_aw_valid = 1'b1;
        wait_hi(0, "aw", n);
        @(posedge clk); #1;
        axi_aw_valid = 1'b0;
        for (int i = 0; i < nb; i++) begin
            axi_w_data = wd[i]; axi_w_strb = ws[i];
            axi_w_last = (i == last_at); axi_w_valid = 1'b1;
            wait_hi(1, "w", n);
            a = beat_addr(addr, i, sz, bu);
            if (beat_err(a, sz, bu)) any_err = 1'b1;
            else begin
                for (int b = 0; b < 8; b++) begin
                    if (ws[i][b]) begin
                        mw[a >> 3][b*8 +: 8] = wd[i][b*8 +: 8];
                        mm[a >> 3][b*8 +: 8] = 8'hFF;
                    end
                end
            end
            @(posedge clk); #1;
        end
        axi_w_valid = 1'b0; axi_w_last = 1'b0;
        if (abort_n >= 0) return;
        b_q.push_back('{id, any_err ? 2'b10 : 2'b00});
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1 && chk_lat) chk("b_latency", 64'(axi_b_valid), 64'd1);
        end while (!(axi_b_valid && axi_b_ready) && n < TMO);
        if (n >= TMO) begin
            checks++; failures++;
            $display("FAIL b_timeout actual=no_handshake required=handshake");
        end
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [2:0] sz, input logic [1:0] bu, input bit chk_lat);
        int n;
        logic [31:0] a;
        for (int i = 0; i <= len; i++) begin
            a = beat_addr(addr, i, sz, bu);
            if (beat_err(a, sz, bu)) r_q.push_back('{id, 64'd0, '1, 2'b10, i == len});
            else r_q.push_back('{id, mw[a >> 3], mm[a >> 3], 2'b00, i == len});
        end
        axi_ar_id = id; axi_ar_addr = addr; axi_ar_len = 8'(len);
        axi_ar_size = sz; axi_ar_burst = bu; axi_ar_valid = 1'b1;
        wait_hi(2, "ar", n);
        @(posedge clk); #1;
        axi_ar_valid = 1'b0;
        wait_hi(3, "r_valid", n);
        if (chk_lat) chk("r_latency", 64'(n), 64'(1 + READ_LAT));
        n = 0;
        while (r_q.size() != 0 && n < 4 * TMO) begin
            @(negedge clk);
            n++;
        end
        if (r_q.size() != 0) begin
            checks++; failures++;
            $display("FAIL r_drain actual=%0d required=0", r_q.size());
            r_q.delete();
        end
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor: compare the head entry every cycle a response is shown, pop on handshake
    always @(negedge clk) begin
        if (!rst) begin
            if (axi_r_valid) begin
                if (r_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL r_unexpected actual=valid required=idle");
                end else begin
                    chk("r_data", axi_r_data & r_q[0].mask, r_q[0].data & r_q[0].mask);
                    chk("r_resp", 64'(axi_r_resp), 64'(r_q[0].resp));
                    chk("r_last", 64'(axi_r_last), 64'(r_q[0].last));
                    chk("r_id", 64'(axi_r_id), 64'(r_q[0].id));
                    if (axi_r_ready) void'(r_q.pop_front());
                end
            end
            if (axi_b_valid) begin
                if (b_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL b_unexpected actual=valid required=idle");
                end else begin
                    chk("b_resp", 64'(axi_b_resp), 64'(b_q[0].resp));
                    chk("b_id", 64'(axi_b_id), 64'(b_q[0].id));
                    if (axi_b_ready) void'(b_q.pop_front());
                end
            end
        end
    end

    initial begin
        axi_r_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rr_mode)
                0: axi_r_ready = 1'b1;
                1: axi_r_ready = ~axi_r_ready;
                default: axi_r_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        axi_b_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            axi_b_ready = (bb_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check_idle(input string tag);
        chk({tag, "_aw_ready"}, 64'(axi_aw_ready), 64'd1);
        chk({tag, "_ar_ready"}, 64'(axi_ar_ready), 64'd1);
        chk({tag, "_w_ready"}, 64'(axi_w_ready), 64'd0);
        chk({tag, "_b_valid"}, 64'(axi_b_valid), 64'd0);
        chk({tag, "_r_valid"}, 64'(axi_r_valid), 64'd0);
        chk({tag, "_r_last"}, 64'(axi_r_last), 64'd0);
        chk({tag, "_resps"}, 64'({axi_b_resp, axi_r_resp}), 64'd0);
        chk({tag, "_ids"}, 64'({axi_b_id, axi_r_id}), 64'd0);
        chk({tag, "_r_data"}, axi_r_data, 64'd0);
    endtask

    task automatic fill_rand(input int n, input bit full_strb);
        for (int i = 0; i < n; i++) begin
            wd[i] = {$urandom, $urandom};
            ws[i] = full_strb ? 8'hFF : 8'($urandom);
        end
    endtask

    initial begin
        int len, last_at;
        logic [31:0] addr;
        logic [2:0]  sz;
        logic [1:0]  bu;
        for (int i = 0; i < int'(DEPTH); i++) begin
            mw[i] = '0;
            mm[i] = '0;
        end
        rst = 1'b1;
        axi_aw_valid = 0; axi_w_valid = 0; axi_ar_valid = 0; axi_w_last = 0;
        axi_aw_id = 0; axi_aw_addr = 0; axi_aw_len = 0; axi_aw_size = 0; axi_aw_burst = 0;
        axi_ar_id = 0; axi_ar_addr = 0; axi_ar_len = 0; axi_ar_size = 0; axi_ar_burst = 0;
        axi_w_data = 0; axi_w_strb = 0;

        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check_idle("reset");
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle("post_reset");
        @(posedge clk); #1;

        // single partial-strobe write then read back
        wd[0] = 64'h1122334455667788; ws[0] = 8'h0F;
        do_write(4'h3, 32'h10, 0, 3'd3, 2'b01, 0, -1, 1'b1);
        do_read(4'h5, 32'h10, 0, 3'd3, 2'b01, 1'b1);

        // INCR burst read with r_ready toggling
        for (int i = 0; i < 4; i++) begin wd[i] = 64'hA0 + 64'(i); ws[i] = 8'hFF; end
        do_write(4'h1, 32'h0, 3, 3'd3, 2'b01, 3, -1, 1'b0);
        rr_mode = 1;
        do_read(4'hA, 32'h0, 3, 3'd3, 2'b01, 1'b0);
        rr_mode = 0;

        // error responses: out of range read, WRAP write leaves memory untouched
        do_read(4'h6, 32'(DEPTH * 8), 0, 3'd3, 2'b01, 1'b1);
        fill_rand(2, 1'b1);
        do_write(4'h2, 32'h40, 1, 3'd3, 2'b01, 1, -1, 1'b0);
        fill_rand(2, 1'b1);
        do_write(4'h7, 32'h40, 1, 3'd3, 2'b10, 1, -1, 1'b0);
        do_read(4'h8, 32'h40, 1, 3'd3, 2'b01, 1'b0);

        // concurrent write/read on different words, then write-then-read of one word
        fill_rand(1, 1'b1);
        do_write(4'h9, 32'h28, 0, 3'd3, 2'b01, 0, -1, 1'b0);
        fill_rand(1, 1'b1);
        fork
            do_write(4'h2, 32'h20, 0, 3'd3, 2'b01, 0, -1, 1'b1);
            do_read(4'h7, 32'h28, 0, 3'd3, 2'b01, 1'b1);
        join
        fill_rand(1, 1'b1);
        do_write(4'hB, 32'h28, 0, 3'd3, 2'b01, 0, -1, 1'b0);
        do_read(4'hC, 32'h28, 0, 3'd3, 2'b01, 1'b0);

        // reset after two beats of a four-beat write
        fill_rand(4, 1'b1);
        do_write(4'h4, 32'h0, 3, 3'd3, 2'b01, 3, 2, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_w_ready", 64'(axi_w_ready), 64'd0);
        chk("abort_aw_ready", 64'(axi_aw_ready), 64'd1);
        chk("abort_b_valid", 64'(axi_b_valid), 64'd0);
        @(posedge clk); #1;
        do_read(4'hD, 32'h0, 3, 3'd3, 2'b01, 1'b0);

        // randomized traffic
        rr_mode = 2;
        bb_mode = 1;
        for (int it = 0; it < 150; it++) begin
            len = $urandom_range(0, 7);
            addr = ($urandom_range(0, 7) == 0) ? 32'(DEPTH * 8) - 32'($urandom_range(1, 40))
                                               : 32'($urandom_range(0, 1023));
            sz = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 4)) : 3'd3;
            bu = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            last_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 8) : len;
            fill_rand(len + 1, $urandom_range(0, 1) == 1);
            do_write(4'($urandom), addr, len, sz, bu, last_at, -1, 1'b0);
            len = $urandom_range(0, 7);
            addr = ($urandom_range(0, 7) == 0) ? 32'(DEPTH * 8) - 32'($urandom_range(1, 40))
                                               : 32'($urandom_range(0, 1023));
            sz = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 4)) : 3'd3;
            bu = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            do_read(4'($urandom), addr, len, sz, bu, 1'b0);
        end

        repeat (4) @(posedge clk);
        chk("b_queue_empty", 64'(b_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
